// File: rtl/seq_pkg.sv
// Shared types and sizing helpers for the bit serializer that feeds the 1101 detector.
package seq_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  localparam int WORDS_CNT_W = 16;

  // Bit-counter width for a WIDTH-bit word; never collapses to zero bits.
  function automatic int ser_cnt_w(input int width);
    if (width < 2) begin
      return 1;
    end else begin
      return $clog2(width);
    end
  endfunction

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial stage: one-word hold buffer in front of a shifter, one bit per
// clock on ser_out, IDLE_BIT fill whenever no word is streaming.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic                   ser_out,
  output logic                   ser_valid,
  output logic                   word_done,
  output logic [WORDS_CNT_W-1:0] words_sent
);

  localparam int unsigned      CNT_W    = ser_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WIDTH - 2);

  ser_state_t             state_r;
  logic [WIDTH-1:0]       hold_r;
  logic                   hold_full_r;
  logic [WIDTH-1:0]       shift_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   ser_out_r;
  logic                   ser_valid_r;
  logic                   word_done_r;
  logic [WORDS_CNT_W-1:0] words_cnt_r;

  logic accept_s;
  logic take_s;

  // Bit that goes on the line next, taken from the leading end of the word.
  function automatic logic lead_bit(input logic [WIDTH-1:0] word);
    if (MSB_FIRST) begin
      return word[WIDTH-1];
    end else begin
      return word[0];
    end
  endfunction

  // Word with the leading bit consumed, so the next bit moves to the leading end.
  function automatic logic [WIDTH-1:0] consume(input logic [WIDTH-1:0] word);
    if (MSB_FIRST) begin
      return {word[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, word[WIDTH-1:1]};
    end
  endfunction

  // Handshake and hold-to-shifter transfer decisions for the coming edge.
  always_comb begin
    accept_s = 1'b0;
    take_s   = 1'b0;
    accept_s = data_valid && data_ready;
    if (hold_full_r && (state_r == SER_IDLE)) begin
      take_s = 1'b1;
    end else if (hold_full_r && (state_r == SER_SHIFT) && (cnt_r == CNT_LAST)) begin
      take_s = 1'b1;
    end else begin
      take_s = 1'b0;
    end
  end

  // Hold buffer, shifter, bit counter, word counter and serial output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= SER_IDLE;
      hold_r      <= '0;
      hold_full_r <= 1'b0;
      shift_r     <= '0;
      cnt_r       <= '0;
      ser_out_r   <= IDLE_BIT;
      ser_valid_r <= 1'b0;
      word_done_r <= 1'b0;
      words_cnt_r <= '0;
    end else begin
      if (accept_s) begin
        hold_r <= data_in;
      end
      // A new word only lands while hold is empty, so it never races the transfer.
      hold_full_r <= accept_s | (hold_full_r & ~take_s);

      case (state_r)
        SER_IDLE: begin
          if (take_s) begin
            state_r     <= SER_SHIFT;
            shift_r     <= consume(hold_r);
            ser_out_r   <= lead_bit(hold_r);
            ser_valid_r <= 1'b1;
            cnt_r       <= '0;
            word_done_r <= 1'b0;
          end else begin
            ser_out_r   <= IDLE_BIT;
            ser_valid_r <= 1'b0;
            word_done_r <= 1'b0;
          end
        end
        SER_SHIFT: begin
          if (cnt_r == CNT_LAST) begin
            words_cnt_r <= words_cnt_r + WORDS_CNT_W'(1);
            if (take_s) begin
              shift_r     <= consume(hold_r);
              ser_out_r   <= lead_bit(hold_r);
              ser_valid_r <= 1'b1;
              cnt_r       <= '0;
              word_done_r <= 1'b0;
            end else begin
              state_r     <= SER_IDLE;
              ser_out_r   <= IDLE_BIT;
              ser_valid_r <= 1'b0;
              cnt_r       <= '0;
              word_done_r <= 1'b0;
            end
          end else begin
            shift_r     <= consume(shift_r);
            ser_out_r   <= lead_bit(shift_r);
            ser_valid_r <= 1'b1;
            cnt_r       <= cnt_r + CNT_W'(1);
            word_done_r <= (cnt_r == CNT_PRE);
          end
        end
        default: begin
          state_r     <= SER_IDLE;
          ser_out_r   <= IDLE_BIT;
          ser_valid_r <= 1'b0;
          cnt_r       <= '0;
          word_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign data_ready = reset && !hold_full_r;
  assign ser_out    = ser_out_r;
  assign ser_valid  = ser_valid_r;
  assign word_done  = word_done_r;
  assign words_sent = words_cnt_r;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: an 8-bit MSB-first instance and a 4-bit
// LSB-first instance with idle fill of 1.
module tb_seq_bit_serializer;

  logic        clk;
  logic        rst;
  logic [7:0]  din8;
  logic        dv8;
  logic        rdy8, so8, sv8, wd8;
  logic [15:0] ws8;
  logic [3:0]  din4;
  logic        dv4;
  logic        rdy4, so4, sv4, wd4;
  logic [15:0] ws4;

  int vec_cnt;
  int err_cnt;

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut8 (
    .clk(clk), .reset(rst), .data_in(din8), .data_valid(dv8), .data_ready(rdy8),
    .ser_out(so8), .ser_valid(sv8), .word_done(wd8), .words_sent(ws8)
  );

  seq_bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_dut4 (
    .clk(clk), .reset(rst), .data_in(din4), .data_valid(dv4), .data_ready(rdy4),
    .ser_out(so4), .ser_valid(sv4), .word_done(wd4), .words_sent(ws4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    dv8 = 1'b0;
    dv4 = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
  endtask

  logic [7:0]  exp_db;
  logic [3:0]  det_sh;
  logic [23:0] stream;
  logic [23:0] exp_stream;
  logic [3:0]  exp_b4;
  logic        acc;
  int          idx, first_v, last_v, nvalid, pulses, cnt_bad;
  int          acc_cyc [3];
  logic [15:0] ws17;

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst  = 1'b0;
    din8 = 8'h00;
    dv8  = 1'b0;
    din4 = 4'h0;
    dv4  = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_ser_out", {31'd0, so8}, 32'd0);
    chk("rst_ser_valid", {31'd0, sv8}, 32'd0);
    chk("rst_word_done", {31'd0, wd8}, 32'd0);
    chk("rst_words_sent", {16'd0, ws8}, 32'd0);
    chk("rst_ready_low", {31'd0, rdy8}, 32'd0);
    chk("rst_idle_fill4", {31'd0, so4}, 32'd1);
    rst = 1'b1;
    #1;
    chk("ready_after_rst", {31'd0, rdy8}, 32'd1);

    // Single word 8'hDB, MSB first, with a 1101 detector model on the stream
    exp_db = 8'b1101_1011;
    det_sh = 4'b0000;
    din8 = 8'hDB;
    dv8  = 1'b1;
    step();
    dv8 = 1'b0;
    chk("db_not_yet_valid", {31'd0, sv8}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      det_sh = {det_sh[2:0], so8};
      chk($sformatf("db_bit%0d", i), {31'd0, so8}, {31'd0, exp_db[7-i]});
      chk($sformatf("db_valid%0d", i), {31'd0, sv8}, 32'd1);
      chk($sformatf("db_done%0d", i), {31'd0, wd8}, (i == 7) ? 32'd1 : 32'd0);
      chk($sformatf("db_det%0d", i), {31'd0, (det_sh == 4'b1101)},
          ((i == 3) || (i == 6)) ? 32'd1 : 32'd0);
    end
    step();
    chk("db_valid_drop", {31'd0, sv8}, 32'd0);
    chk("db_idle_bit", {31'd0, so8}, 32'd0);
    chk("db_words_sent", {16'd0, ws8}, 32'd1);

    // Back-to-back D0, 0D, then a third word whose data_in changes while stalled
    do_reset();
    idx = 0; first_v = -1; last_v = -1; nvalid = 0; pulses = 0;
    stream = 24'd0; ws17 = 16'd0;
    for (int k = 0; k < 3; k++) acc_cyc[k] = -1;
    for (int c = 0; c < 30; c++) begin
      if (idx == 0) begin
        dv8 = 1'b1; din8 = 8'hD0;
      end else if (idx == 1) begin
        dv8 = 1'b1; din8 = 8'h0D;
      end else if (idx == 2) begin
        dv8 = 1'b1; din8 = 8'hA0 ^ {4'h0, 4'(c)};
      end else begin
        dv8 = 1'b0;
      end
      #1;
      acc = dv8 && rdy8;
      step();
      if (acc) begin
        acc_cyc[idx] = c;
        idx++;
      end
      if (sv8) begin
        stream = {stream[22:0], so8};
        nvalid++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (wd8) pulses++;
      if (c == 17) ws17 = ws8;
    end
    exp_stream = {8'hD0, 8'h0D, 8'hAA};
    chk("b2b_acc0", acc_cyc[0], 32'd0);
    chk("b2b_acc1", acc_cyc[1], 32'd2);
    chk("b2b_acc2", acc_cyc[2], 32'd10);
    chk("b2b_first_valid", first_v, 32'd1);
    chk("b2b_last_valid", last_v, 32'd24);
    chk("b2b_valid_count", nvalid, 32'd24);
    chk("b2b_stream", {8'd0, stream}, {8'd0, exp_stream});
    chk("b2b_done_pulses", pulses, 32'd3);
    chk("b2b_ws_after2", {16'd0, ws17}, 32'd2);
    chk("b2b_ws_final", {16'd0, ws8}, 32'd3);

    // Reset mid-word: 3 bits of FF out, 8'h81 waiting in hold
    do_reset();
    din8 = 8'hFF; dv8 = 1'b1;
    step();
    din8 = 8'h81;
    step();
    step();
    dv8 = 1'b0;
    step();
    chk("mid_bits_running", {31'd0, sv8}, 32'd1);
    chk("mid_hold_full", {31'd0, rdy8}, 32'd0);
    rst = 1'b0;
    step();
    chk("mid_rst_valid", {31'd0, sv8}, 32'd0);
    chk("mid_rst_out", {31'd0, so8}, 32'd0);
    chk("mid_rst_ws", {16'd0, ws8}, 32'd0);
    chk("mid_rst_done", {31'd0, wd8}, 32'd0);
    chk("mid_rst_ready", {31'd0, rdy8}, 32'd0);
    step();
    rst = 1'b1;
    #1;
    chk("mid_ready_release", {31'd0, rdy8}, 32'd1);
    cnt_bad = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (sv8 || wd8) cnt_bad++;
    end
    chk("mid_no_residue", cnt_bad, 32'd0);
    chk("mid_ws_still0", {16'd0, ws8}, 32'd0);

    // WIDTH=4, LSB first, idle fill 1
    do_reset();
    exp_b4 = 4'b1011;
    chk("w4_idle_before", {31'd0, so4}, 32'd1);
    din4 = 4'b1011; dv4 = 1'b1;
    step();
    dv4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("w4_bit%0d", i), {31'd0, so4}, {31'd0, exp_b4[i]});
      chk($sformatf("w4_valid%0d", i), {31'd0, sv4}, 32'd1);
      chk($sformatf("w4_done%0d", i), {31'd0, wd4}, (i == 3) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("w4_idle_out%0d", i), {31'd0, so4}, 32'd1);
      chk($sformatf("w4_idle_valid%0d", i), {31'd0, sv4}, 32'd0);
    end
    chk("w4_ws", {16'd0, ws4}, 32'd1);

    // Word counter wrap, preset near the top
    force u_dut4.words_cnt_r = 16'hFFFE;
    #1;
    release u_dut4.words_cnt_r;
    #1;
    chk("wrap_preset", {16'd0, ws4}, 32'h0000FFFE);
    for (int w = 0; w < 2; w++) begin
      din4 = 4'h6; dv4 = 1'b1;
      step();
      dv4 = 1'b0;
      for (int c = 0; c < 5; c++) step();
      chk($sformatf("wrap_ws%0d", w), {16'd0, ws4}, (w == 0) ? 32'h0000FFFF : 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
